// File: rtl/rf_odp_monitor.sv
// rf_odp_monitor
//   Per-channel RF overdrive protection. Sums NUM_CH unsigned power samples over
//   a programmable window and publishes the saturated sums as TSSI status. In
//   the single cycle after each window closes, it compares every sum against a
//   threshold and latches a sticky per-channel trip. The latched trips drive
//   the PA sleep request.
//
//   Optional build macro: JB_RF_ODP_AUTOCLR_EN
//     When defined, a channel's trip also clears on an evaluation cycle whose
//     sum is at or below the threshold.
//
// Ports
//   clk                  single clock
//   rst_n                asynchronous active-low reset
//   sample_vld           strobe: one valid sample per channel
//   sample_pwr           [NUM_CH][PWR_W] unsigned per-channel power sample
//   rf_overdrive_thresh  32-bit trip threshold (strict greater-than)
//   rf_overdrive_avg_per 21-bit window length in samples, 0 disables the block
//   disable_rf_odp       per-channel trip mask, also clears a latched trip
//   odp_clr              pulse that clears all latched trips
//   rf_overdrive_tssi    [NUM_CH][32] last completed window sum
//   tssi_vld             one-cycle pulse when rf_overdrive_tssi updates
//   odp_trip             latched per-channel overdrive
//   odp_alarm            registered OR of odp_trip
module rf_odp_monitor #(
    parameter int NUM_CH = 8,
    parameter int PWR_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_vld,
    input  logic [NUM_CH-1:0][PWR_W-1:0] sample_pwr,
    input  logic [31:0]                  rf_overdrive_thresh,
    input  logic [20:0]                  rf_overdrive_avg_per,
    input  logic [NUM_CH-1:0]            disable_rf_odp,
    input  logic                         odp_clr,
    output logic [NUM_CH-1:0][31:0]      rf_overdrive_tssi,
    output logic                         tssi_vld,
    output logic [NUM_CH-1:0]            odp_trip,
    output logic                         odp_alarm
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] EVAL  = 2'd2;

    logic [1:0]               state;
    logic [20:0]              win_len;
    logic [20:0]              cnt;
    logic [NUM_CH-1:0][31:0]  acc;
    logic [NUM_CH-1:0][31:0]  acc_sum;
    logic [32:0]              sum_wide [NUM_CH];
    logic [NUM_CH-1:0]        trip_next;

    logic        running;
    logic        accept;
    logic        last;
    logic [20:0] len_eff;

    assign running = (rf_overdrive_avg_per != '0);
    assign accept  = sample_vld && running && ((state == ACCUM) || (state == EVAL));
    // EVAL is also the first cycle of the next window, so its length comes
    // straight from the input rather than the previously latched value.
    assign len_eff = (state == EVAL) ? rf_overdrive_avg_per : win_len;
    assign last    = accept && ((cnt + 21'd1) == len_eff);

    // Saturating add of the current sample onto each accumulator.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum_wide[i] = {1'b0, acc[i]} + 33'(sample_pwr[i]);
            acc_sum[i]  = sum_wide[i][32] ? '1 : sum_wide[i][31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            win_len           <= '0;
            cnt               <= '0;
            acc               <= '0;
            rf_overdrive_tssi <= '0;
            tssi_vld          <= 1'b0;
        end else begin
            tssi_vld <= 1'b0;
            if (!running) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= ACCUM;
                        win_len <= rf_overdrive_avg_per;
                    end
                    ACCUM, EVAL: begin
                        if (state == EVAL) begin
                            win_len <= rf_overdrive_avg_per;
                        end
                        if (last) begin
                            rf_overdrive_tssi <= acc_sum;
                            tssi_vld          <= 1'b1;
                            acc               <= '0;
                            cnt               <= '0;
                            state             <= EVAL;
                        end else begin
                            if (accept) begin
                                acc <= acc_sum;
                                cnt <= cnt + 21'd1;
                            end
                            state <= ACCUM;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Priority: mask clears, then a fresh trip, then clear requests.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            trip_next[i] = odp_trip[i];
            if (disable_rf_odp[i]) begin
                trip_next[i] = 1'b0;
            end else if ((state == EVAL) && (rf_overdrive_tssi[i] > rf_overdrive_thresh)) begin
                trip_next[i] = 1'b1;
            end else if (odp_clr) begin
                trip_next[i] = 1'b0;
`ifdef JB_RF_ODP_AUTOCLR_EN
            end else if (state == EVAL) begin
                trip_next[i] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odp_trip  <= '0;
            odp_alarm <= 1'b0;
        end else begin
            odp_trip  <= trip_next;
            odp_alarm <= |odp_trip;
        end
    end

endmodule

// File: tb/tb_rf_odp_monitor.sv
// tb_rf_odp_monitor
//   Directed bench for rf_odp_monitor (NUM_CH=4, PWR_W=32). Inputs are driven
//   1 time unit after the rising edge and outputs are sampled at the same point.
module tb_rf_odp_monitor;

    localparam int NUM_CH = 4;
    localparam int PWR_W  = 32;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         sample_vld;
    logic [NUM_CH-1:0][PWR_W-1:0] sample_pwr;
    logic [31:0]                  rf_overdrive_thresh;
    logic [20:0]                  rf_overdrive_avg_per;
    logic [NUM_CH-1:0]            disable_rf_odp;
    logic                         odp_clr;
    logic [NUM_CH-1:0][31:0]      rf_overdrive_tssi;
    logic                         tssi_vld;
    logic [NUM_CH-1:0]            odp_trip;
    logic                         odp_alarm;

    int n_checks = 0;
    int n_errors = 0;

    rf_odp_monitor #(.NUM_CH(NUM_CH), .PWR_W(PWR_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sample_vld           (sample_vld),
        .sample_pwr           (sample_pwr),
        .rf_overdrive_thresh  (rf_overdrive_thresh),
        .rf_overdrive_avg_per (rf_overdrive_avg_per),
        .disable_rf_odp       (disable_rf_odp),
        .odp_clr              (odp_clr),
        .rf_overdrive_tssi    (rf_overdrive_tssi),
        .tssi_vld             (tssi_vld),
        .odp_trip             (odp_trip),
        .odp_alarm            (odp_alarm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n                = 1'b0;
        sample_vld           = 1'b0;
        sample_pwr           = '0;
        rf_overdrive_thresh  = '0;
        rf_overdrive_avg_per = '0;
        disable_rf_odp       = '0;
        odp_clr              = 1'b0;
        tick();
        tick();
        check_eq("rst_tssi0", rf_overdrive_tssi[0], 0);
        check_eq("rst_vld", tssi_vld, 0);
        check_eq("rst_trip", odp_trip, 0);
        check_eq("rst_alarm", odp_alarm, 0);
        rst_n = 1'b1;

        // Window of 4 x 100, threshold 399 -> trip
        rf_overdrive_thresh  = 32'd399;
        rf_overdrive_avg_per = 21'd4;
        tick();
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd100;
        tick(); tick(); tick();
        check_eq("t1_vld_early", tssi_vld, 0);
        tick();
        sample_vld = 1'b0;
        check_eq("t1_tssi", rf_overdrive_tssi[0], 400);
        check_eq("t1_vld", tssi_vld, 1);
        check_eq("t1_trip_early", odp_trip[0], 0);
        tick();
        check_eq("t1_trip", odp_trip[0], 1);
        check_eq("t1_vld_pulse", tssi_vld, 0);
        check_eq("t1_alarm_early", odp_alarm, 0);
        tick();
        check_eq("t1_alarm", odp_alarm, 1);

        // Same stimulus with threshold 400 -> no trip
        rf_overdrive_thresh = 32'd400;
        odp_clr = 1'b1;
        tick();
        odp_clr = 1'b0;
        check_eq("t2_clr", odp_trip[0], 0);
        sample_vld = 1'b1;
        tick(); tick(); tick(); tick();
        sample_vld = 1'b0;
        check_eq("t2_tssi", rf_overdrive_tssi[0], 400);
        check_eq("t2_vld", tssi_vld, 1);
        tick();
        check_eq("t2_no_trip", odp_trip[0], 0);
        tick();
        check_eq("t2_no_alarm", odp_alarm, 0);

        // Saturation, window of 3
        rf_overdrive_avg_per = 21'd0;
        tick();
        rf_overdrive_thresh  = 32'hFFFF_FFFE;
        rf_overdrive_avg_per = 21'd3;
        tick();
        sample_vld = 1'b1;
        sample_pwr[0] = 32'hFFFF_FFF0;
        sample_pwr[1] = 32'h0000_FFFF;
        tick();
        sample_pwr[0] = 32'h0000_FFFF;
        tick(); tick();
        sample_vld = 1'b0;
        check_eq("t3_sat", rf_overdrive_tssi[0], 64'hFFFF_FFFF);
        check_eq("t3_ch1", rf_overdrive_tssi[1], 64'h2_FFFD);
        tick();
        check_eq("t3_trip0", odp_trip[0], 1);
        check_eq("t3_trip1", odp_trip[1], 0);

        // odp_clr coinciding with an EVAL re-trip
        sample_vld = 1'b1;
        sample_pwr[0] = 32'hFFFF_FFFF;
        sample_pwr[1] = 32'd0;
        tick(); tick(); tick();
        sample_vld = 1'b0;
        check_eq("t4_tssi", rf_overdrive_tssi[0], 64'hFFFF_FFFF);
        odp_clr = 1'b1;
        tick();
        odp_clr = 1'b0;
        check_eq("t4_set_wins", odp_trip[0], 1);
        rf_overdrive_thresh = 32'd399;
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd50;
        tick(); tick(); tick();
        sample_vld = 1'b0;
        check_eq("t4_tssi150", rf_overdrive_tssi[0], 150);
        tick();
`ifdef JB_RF_ODP_AUTOCLR_EN
        check_eq("t4_autoclr", odp_trip[0], 0);
`else
        check_eq("t4_sticky", odp_trip[0], 1);
`endif
        odp_clr = 1'b1;
        tick();
        odp_clr = 1'b0;
        check_eq("t4_clr", odp_trip[0], 0);

        // Per-channel mask: blocks a trip, clears a latched trip
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd200;
        sample_pwr[1] = 32'd200;
        tick(); tick(); tick();
        sample_vld = 1'b0;
        disable_rf_odp = 4'b0010;
        tick();
        check_eq("t5_trip0", odp_trip[0], 1);
        check_eq("t5_masked1", odp_trip[1], 0);
        disable_rf_odp = 4'b0001;
        tick();
        check_eq("t5_dis_clr", odp_trip[0], 0);
        disable_rf_odp = '0;
        sample_pwr[1] = 32'd0;

        // Reset mid-window discards the partial sum
        rf_overdrive_avg_per = 21'd0;
        tick();
        rf_overdrive_avg_per = 21'd4;
        tick();
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd999;
        tick(); tick();
        sample_vld = 1'b0;
        rst_n = 1'b0;
        #2;
        check_eq("t6_async_tssi", rf_overdrive_tssi[0], 0);
        check_eq("t6_async_vld", tssi_vld, 0);
        tick();
        rst_n = 1'b1;
        tick();
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd10;
        tick(); tick(); tick(); tick();
        sample_vld = 1'b0;
        check_eq("t6_tssi40", rf_overdrive_tssi[0], 40);
        check_eq("t6_vld", tssi_vld, 1);

        // avg_per 4 -> 2 mid-window takes effect at next window
        tick();
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd1;
        tick(); tick();
        rf_overdrive_avg_per = 21'd2;
        check_eq("t7_no_vld2", tssi_vld, 0);
        tick();
        check_eq("t7_no_vld3", tssi_vld, 0);
        tick();
        sample_vld = 1'b0;
        check_eq("t7_tssi4", rf_overdrive_tssi[0], 4);
        check_eq("t7_vld4", tssi_vld, 1);
        tick();
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd5;
        tick();
        check_eq("t7_no_vld_w2", tssi_vld, 0);
        tick();
        sample_vld = 1'b0;
        check_eq("t7_tssi10", rf_overdrive_tssi[0], 10);
        check_eq("t7_vld_w2", tssi_vld, 1);
        rf_overdrive_avg_per = 21'd0;
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd77;
        tick(); tick();
        sample_vld = 1'b0;
        check_eq("t7_idle_hold", rf_overdrive_tssi[0], 10);
        check_eq("t7_idle_vld", tssi_vld, 0);

        // Window length 1: every sample closes a window, including one in EVAL
        rf_overdrive_avg_per = 21'd1;
        tick();
        sample_vld = 1'b1;
        sample_pwr[0] = 32'd7;
        tick();
        check_eq("t8_tssi7", rf_overdrive_tssi[0], 7);
        check_eq("t8_vld7", tssi_vld, 1);
        sample_pwr[0] = 32'd8;
        tick();
        check_eq("t8_tssi8", rf_overdrive_tssi[0], 8);
        check_eq("t8_vld8", tssi_vld, 1);
        sample_vld = 1'b0;
        tick();
        check_eq("t8_vld_end", tssi_vld, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
